// File: rtl/fft_comp_sched.sv
// fft_comp_sched - frame-level controller for the pipelined FFT datapath.
//
// Takes one job descriptor at a time and holds it as stable configuration
// for the datapath. It gates DMA->compute so exactly 2^point samples enter,
// and counts 2^point samples leaving towards the bit-reverse FIFO. It also
// signals frame completion before the next descriptor can be accepted.
//
// Optional feature: define FFT_SCHED_TIMEOUT_EN to add a drain watchdog. When
// DRAIN sees no output for TIMEOUT cycles, the frame is aborted with a
// one-cycle timeout pulse.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cfg_valid / cfg_ready   descriptor handshake
//   cfg_point/ifft/scaling/shift   descriptor fields
//   dma_valid / dma_ready   DMA side of the input stream
//   comp_in_valid / comp_ready_out  compute side of the input stream
//   comp_out_valid, sink_ready      compute output -> bit-reverse FIFO
//   point/ifft/scaling/shift_back   active configuration (held)
//   busy        frame in progress
//   frame_done  one-cycle completion pulse
//   cfg_err     one-cycle illegal-descriptor pulse
//   timeout     one-cycle watchdog pulse (0 without the watchdog)
module fft_comp_sched #(
  parameter int MAX_LOG2 = 13,
  parameter int CNT_W    = MAX_LOG2 + 1,
  parameter int TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_point,
  input  logic                  cfg_ifft,
  input  logic [2*MAX_LOG2-1:0] cfg_scaling,
  input  logic [4:0]            cfg_shift,
  input  logic                  dma_valid,
  output logic                  dma_ready,
  output logic                  comp_in_valid,
  input  logic                  comp_ready_out,
  input  logic                  comp_out_valid,
  input  logic                  sink_ready,
  output logic [3:0]            point,
  output logic                  ifft,
  output logic [2*MAX_LOG2-1:0] scaling,
  output logic [4:0]            shift_back,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam logic [3:0]       MAX_PT = 4'(MAX_LOG2);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic [CNT_W-1:0] n_cnt;
  logic             in_fire, out_fire, out_cnt_en;
  logic             last_in, done_hit, cfg_legal;

  assign cfg_ready     = (state == IDLE);
  assign dma_ready     = comp_ready_out & (state == LOAD);
  assign comp_in_valid = dma_valid & (state == LOAD);
  assign in_fire       = dma_valid & dma_ready;
  assign out_fire      = comp_out_valid & sink_ready;

  assign n_cnt     = ONE << point;
  assign cfg_legal = (cfg_point != 4'd0) && (cfg_point <= MAX_PT);
  assign last_in   = (in_cnt == n_cnt - ONE);
  // Output counting is live in LOAD and DRAIN; it saturates at N, and any
  // out_fire seen in IDLE is ignored.
  assign out_cnt_en = out_fire && (state != IDLE) && (out_cnt != n_cnt);
  assign done_hit   = out_cnt_en && (out_cnt == n_cnt - ONE);

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
  logic            timeout_q;
  assign timeout = timeout_q;
`else
  // Without the watchdog, TIMEOUT has no effect; this term folds to 0.
  assign timeout = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      point      <= '0;
      ifft       <= 1'b0;
      scaling    <= '0;
      shift_back <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
      wd         <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_legal) begin
              point      <= cfg_point;
              ifft       <= cfg_ifft;
              scaling    <= cfg_scaling;
              shift_back <= cfg_shift;
              in_cnt     <= '0;
              out_cnt    <= '0;
              busy       <= 1'b1;
              state      <= LOAD;
            end else begin
              // An illegal descriptor is consumed and the configuration is left alone.
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_fire)    in_cnt  <= in_cnt + ONE;
          if (out_cnt_en) out_cnt <= out_cnt + ONE;
          // When the final input and the final output arrive together, completion wins.
          if (done_hit) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else if (in_fire && last_in) begin
            state <= DRAIN;
`ifdef FFT_SCHED_TIMEOUT_EN
            wd    <= '0;
`endif
          end
        end
        DRAIN: begin
          if (out_cnt_en) out_cnt <= out_cnt + ONE;
          if (done_hit) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
`ifdef FFT_SCHED_TIMEOUT_EN
          else if (out_fire) begin
            wd <= '0;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            // Abort the frame and keep the configuration. No frame_done is emitted.
            state     <= IDLE;
            busy      <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_comp_sched.sv
// Bench for fft_comp_sched. A frame-level model (sample counts, not state
// encodings) predicts every output and is compared on each falling edge.
// Directed scenarios also pin a few literal values.
module tb_fft_comp_sched;
  localparam int ML = 13;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_valid, cfg_ifft, dma_valid, comp_ready_out;
  logic            comp_out_valid, sink_ready;
  logic [3:0]      cfg_point;
  logic [2*ML-1:0] cfg_scaling;
  logic [4:0]      cfg_shift;
  logic            cfg_ready, dma_ready, comp_in_valid, ifft, busy;
  logic            frame_done, cfg_err, timeout;
  logic [3:0]      point;
  logic [2*ML-1:0] scaling;
  logic [4:0]      shift_back;

  always #5 clk = ~clk;

  fft_comp_sched #(.MAX_LOG2(ML), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_point(cfg_point),
    .cfg_ifft(cfg_ifft), .cfg_scaling(cfg_scaling), .cfg_shift(cfg_shift),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .comp_in_valid(comp_in_valid),
    .comp_ready_out(comp_ready_out), .comp_out_valid(comp_out_valid),
    .sink_ready(sink_ready), .point(point), .ifft(ifft), .scaling(scaling),
    .shift_back(shift_back), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err), .timeout(timeout)
  );

  int checks = 0, fails = 0;
  int n_done = 0, n_err = 0, n_to = 0, n_in = 0;

  // frame-level model
  bit              m_active, m_done, m_err, m_to;
  int              m_n, m_ins, m_outs, m_wd;
  logic [3:0]      m_point;
  logic            m_ifft;
  logic [2*ML-1:0] m_scal;
  logic [4:0]      m_shift;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit loading, drain, inf, outf, nd, ne, nt;
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_err = 0; m_to = 0;
      m_n = 0; m_ins = 0; m_outs = 0; m_wd = 0;
      m_point = '0; m_ifft = 0; m_scal = '0; m_shift = '0;
    end
    loading = m_active && (m_ins < m_n);
    chk("cfg_ready", cfg_ready, !m_active);
    chk("dma_ready", dma_ready, comp_ready_out && loading);
    chk("comp_in_valid", comp_in_valid, dma_valid && loading);
    chk("point", point, m_point);
    chk("ifft", ifft, m_ifft);
    chk("scaling", scaling, m_scal);
    chk("shift_back", shift_back, m_shift);
    chk("busy", busy, m_active);
    chk("frame_done", frame_done, m_done);
    chk("cfg_err", cfg_err, m_err);
    chk("timeout", timeout, m_to);
    if (frame_done) n_done++;
    if (cfg_err) n_err++;
    if (timeout) n_to++;
    if (dma_valid && dma_ready) n_in++;
    if (rst_n) begin
      nd = 0; ne = 0; nt = 0;
      if (!m_active) begin
        if (cfg_valid) begin
          if (cfg_point >= 1 && cfg_point <= ML) begin
            m_point = cfg_point; m_ifft = cfg_ifft; m_scal = cfg_scaling; m_shift = cfg_shift;
            m_n = 1 << cfg_point; m_ins = 0; m_outs = 0; m_active = 1;
          end else ne = 1;
        end
      end else begin
        drain = (m_ins == m_n);
        inf   = dma_valid && comp_ready_out && !drain;
        outf  = comp_out_valid && sink_ready;
        if (inf) m_ins++;
        if (outf && m_outs < m_n) m_outs++;
        if (m_outs == m_n) begin
          m_active = 0; nd = 1;
        end
`ifdef FFT_SCHED_TIMEOUT_EN
        else if (drain) begin
          if (outf) m_wd = 0;
          else begin
            m_wd++;
            if (m_wd == TO) begin m_active = 0; nt = 1; end
          end
        end else if (m_ins == m_n) m_wd = 0;
`endif
      end
      m_done = nd; m_err = ne; m_to = nt;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; dma_valid = 0; comp_ready_out = 0; comp_out_valid = 0; sink_ready = 0;
  endtask

  task automatic send_cfg(input logic [3:0] p, input logic f, input logic [2*ML-1:0] s, input logic [4:0] sh);
    cfg_valid = 1; cfg_point = p; cfg_ifft = f; cfg_scaling = s; cfg_shift = sh;
    step();
    cfg_valid = 0;
  endtask

  // Drive the sink and DMA fully open until the model reports the frame as closed.
  task automatic drain_idle(input int max, input string name);
    int k;
    dma_valid = 1; comp_ready_out = 1; comp_out_valid = 1; sink_ready = 1;
    for (k = 0; k < max && m_active; k++) step();
    chk({name, "_bounded"}, m_active, 0);
    idle_inputs();
    step(); step();
  endtask

  initial begin
    int d0, e0, i0, t0;
    rst_n = 0; cfg_point = 0; cfg_ifft = 0; cfg_scaling = 0; cfg_shift = 0;
    idle_inputs();
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1;
    step();

    // illegal descriptors: point 0, then point 14
    e0 = n_err;
    cfg_valid = 1; cfg_point = 0; cfg_scaling = '1; step();
    cfg_point = 14; step();
    cfg_valid = 0; step(); step();
    chk("bad_cfg_err_count", n_err - e0, 2);
    chk("bad_cfg_busy", busy, 0);
    chk("bad_cfg_point", point, 0);
    chk("bad_cfg_scaling", scaling, 0);

    // point=4, DMA always valid, sink always ready, outputs lag inputs by 3
    d0 = n_done; i0 = n_in;
    send_cfg(4'd4, 1'b0, 26'h0123456, 5'd2);
    dma_valid = 1; comp_ready_out = 1; sink_ready = 1;
    for (int k = 0; k < 200 && n_done == d0; k++) begin
      comp_out_valid = (k >= 3);
      step();
    end
    idle_inputs(); step();
    chk("p4_in_count", n_in - i0, 16);
    chk("p4_done_count", n_done - d0, 1);
    chk("p4_point_held", point, 4);
    chk("p4_shift_held", shift_back, 2);
    chk("p4_cfg_ready_after", cfg_ready, 1);

    // point=3: comp_ready toggles, sink stalls for 5 cycles while draining
    d0 = n_done; i0 = n_in;
    send_cfg(4'd3, 1'b1, 26'h2AAAAAA, 5'd7);
    dma_valid = 1;
    for (int k = 0; k < 300 && n_done == d0; k++) begin
      comp_ready_out = k[0];
      comp_out_valid = (k >= 14);
      sink_ready = !(k >= 17 && k < 22);
      step();
    end
    idle_inputs(); step();
    chk("p3_in_count", n_in - i0, 8);
    chk("p3_done_count", n_done - d0, 1);

    // cfg_valid held high through a point=2 frame
    d0 = n_done;
    cfg_valid = 1; cfg_point = 2; cfg_ifft = 0; cfg_scaling = '0; cfg_shift = 1;
    step();
    cfg_scaling = 26'h3FFFFFF;
    dma_valid = 1; comp_ready_out = 1; comp_out_valid = 1; sink_ready = 1;
    for (int k = 0; k < 100 && n_done == d0; k++) step();
    chk("hold_first_done", n_done - d0, 1);
    step(); step();
    chk("hold_second_scaling", scaling, 26'h3FFFFFF);
    chk("hold_second_busy", busy, 1);
    cfg_valid = 0;
    drain_idle(200, "hold");

    // asynchronous reset after 5 inputs of a point=5 frame
    d0 = n_done; i0 = n_in;
    send_cfg(4'd5, 1'b1, 26'h155AA55, 5'd9);
    dma_valid = 1; comp_ready_out = 1;
    repeat (5) step();
    dma_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_point", point, 0);
    chk("arst_scaling", scaling, 0);
    chk("arst_shift", shift_back, 0);
    chk("arst_cfg_ready", cfg_ready, 1);
    chk("arst_dma_ready", dma_ready, 0);
    step();
    rst_n = 1;
    step();
    chk("arst_in_count", n_in - i0, 5);
    chk("arst_no_done", n_done - d0, 0);
    i0 = n_in;
    send_cfg(4'd1, 1'b0, 26'h0000003, 5'd0);
    dma_valid = 1; comp_ready_out = 1;
    step(); step();
    chk("p1_in_count", n_in - i0, 2);
    comp_out_valid = 1; sink_ready = 1;
    for (int k = 0; k < 20 && n_done == d0; k++) step();
    idle_inputs(); step();
    chk("p1_done_count", n_done - d0, 1);
    chk("p1_in_final", n_in - i0, 2);

`ifdef FFT_SCHED_TIMEOUT_EN
    // watchdog: sink never ready after loading
    d0 = n_done; t0 = n_to;
    send_cfg(4'd2, 1'b0, 26'h00000F0, 5'd3);
    dma_valid = 1; comp_ready_out = 1; comp_out_valid = 1; sink_ready = 0;
    for (int k = 0; k < 100 && n_to == t0; k++) step();
    idle_inputs(); step();
    chk("wd_timeout_count", n_to - t0, 1);
    chk("wd_no_done", n_done - d0, 0);
    chk("wd_busy", busy, 0);
    chk("wd_point_held", point, 2);
`else
    t0 = n_to;
`endif

    // randomized traffic, descriptors mostly legal with some illegal ones
    for (int c = 0; c < 4000; c++) begin
      cfg_valid      = ($urandom_range(0, 3) == 0);
      cfg_point      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(14, 15))
                                                   : 4'($urandom_range(1, 5));
      cfg_ifft       = 1'($urandom);
      cfg_scaling    = 26'($urandom);
      cfg_shift      = 5'($urandom);
      dma_valid      = ($urandom_range(0, 3) != 0);
      comp_ready_out = ($urandom_range(0, 3) != 0);
      comp_out_valid = ($urandom_range(0, 2) != 0);
      sink_ready     = ($urandom_range(0, 3) != 0);
      step();
    end
    cfg_valid = 0;
    drain_idle(500, "rand");
`ifndef FFT_SCHED_TIMEOUT_EN
    chk("no_timeout_pulses", n_to - t0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fft_comp_sched.md
Name: fft_comp_sched

Overview:
- Frame-level controller for the pipelined FFT compute datapath.
- Accepts one job descriptor at a time (point, ifft, per-stage scaling, shift_back) and holds it as stable configuration for the datapath.
- Gates the DMA-to-compute valid/ready so exactly 2^point samples enter, counts 2^point samples leaving to the bit-reverse FIFO, and signals frame completion before the next descriptor is accepted.

Parameters:
- MAX_LOG2, 13, log2 of largest supported FFT size; legal point range 1..MAX_LOG2.
- CNT_W, MAX_LOG2+1, sample counter width.
- TIMEOUT, 4096, drain watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_valid  in  1  descriptor offered.
- cfg_ready  out  1  descriptor can be taken.
- cfg_point  in  4  log2 FFT size.
- cfg_ifft  in  1  inverse transform.
- cfg_scaling  in  2*MAX_LOG2  2-bit scaling per stage.
- cfg_shift  in  5  shift_back amount.
- dma_valid  in  1  DMA sample valid.
- dma_ready  out  1  ready back to DMA.
- comp_in_valid  out  1  gated valid into compute.
- comp_ready_out  in  1  compute input ready.
- comp_out_valid  in  1  compute output valid.
- sink_ready  in  1  bit-reverse FIFO ready.
- point  out  4  active point.
- ifft  out  1  active ifft flag.
- scaling  out  2*MAX_LOG2  active scaling.
- shift_back  out  5  active shift.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle illegal-descriptor pulse.
- timeout  out  1  one-cycle watchdog pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset: state IDLE; all counters 0; point, ifft, scaling, shift_back = 0; busy, frame_done, cfg_err, timeout = 0.
- Handshakes:
  - cfg_ready = (state==IDLE).
  - dma_ready = comp_ready_out & (state==LOAD).
  - comp_in_valid = dma_valid & (state==LOAD).
  - in_fire = dma_valid & dma_ready; out_fire = comp_out_valid & sink_ready.
  - All of the above are combinational from registered state and inputs; no added latency on the data path.
- N = 1 << point, computed in CNT_W bits.
- IDLE:
  - On cfg_valid with cfg_point in 1..MAX_LOG2: register all cfg_* into the config outputs, clear in_cnt and out_cnt, go to LOAD, busy=1 from the next cycle.
  - On cfg_valid with cfg_point 0 or >MAX_LOG2: descriptor is consumed, cfg_err pulses the next cycle, state stays IDLE, config outputs unchanged.
- LOAD:
  - in_cnt increments on in_fire.
  - An in_fire with in_cnt==N-1 moves state to DRAIN.
  - out_fire also counts in LOAD, since outputs may overlap the input tail.
- DRAIN:
  - No new input accepted; out_cnt increments on out_fire.
  - An out_fire with out_cnt==N-1 (in LOAD or DRAIN) completes the frame.
- Frame completion:
  - State goes to IDLE, frame_done pulses for one cycle, busy falls.
  - Config outputs are held until the next accepted descriptor.
  - The completing cycle has cfg_ready=0; the next descriptor is accepted no earlier than the following cycle.
- out_cnt saturates at N; extra out_fire beyond N, or any out_fire in IDLE, is ignored.
- Config outputs never change while busy=1.
- Simultaneous in_fire at N-1 and out_fire at N-1 in LOAD (possible only at point=1 corner): completion wins and state goes directly to IDLE.
- Asynchronous reset mid-frame returns everything to reset values immediately; partial frame is abandoned and no frame_done is emitted.

Optional Feature:
- Macro: FFT_SCHED_TIMEOUT_EN.
- When defined:
  - A watchdog counter clears on every out_fire and on entry to DRAIN, and increments each DRAIN cycle without out_fire.
  - At TIMEOUT it forces state to IDLE, pulses timeout for one cycle, and suppresses frame_done.
  - Config outputs are held.
- When undefined: no watchdog logic; timeout tied 0; DRAIN waits indefinitely.

Test Plan:
- Reset, then cfg point=4, ifft=0, shift=2 with DMA always valid and sink always ready -> exactly 16 in_fire, then after 16 out_fire a single frame_done; config outputs stable throughout; cfg_ready high the cycle after.
- Descriptor with point=0, then point=14 -> cfg_err pulses twice, busy stays 0, config outputs remain at reset zero.
- Point=3 with comp_ready_out toggling every cycle and sink_ready low for 5 cycles mid-drain -> in_cnt stops at 8, dma_ready=0 in DRAIN, frame_done only after the 8th out_fire.
- cfg_valid held high during a point=2 frame -> second descriptor accepted only the cycle after frame_done; scaling=26'h3FFFFFF of the second descriptor does not appear on outputs before then.
- Assert rst_n low after 5 inputs of a point=5 frame -> all outputs zero asynchronously, no frame_done; a new point=1 frame then completes after 2 in and 2 out.
- With FFT_SCHED_TIMEOUT_EN and TIMEOUT=16, point=2, sink_ready held low after load -> timeout pulse 16 cycles into DRAIN, state IDLE, no frame_done.
